// File: rtl/ctrl_pkg.sv
// Shared types for the multi-cycle sequencer: opcodes, states, pc_src codes
// and the instruction classes produced by the decoder.
package ctrl_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_LW   = 4'b1011;
  localparam logic [3:0] OP_SW   = 4'b1111;
  localparam logic [3:0] OP_BEQ  = 4'b1000;
  localparam logic [3:0] OP_JMP  = 4'b0010;

  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    CL_ALU,
    CL_LOAD,
    CL_STORE,
    CL_BRANCH,
    CL_JUMP,
    CL_ILL
  } op_class_t;

endpackage

// File: rtl/seq_control_unit_if.sv
// Shared memory port: request/ready handshake plus read/write qualifiers.
// master = sequencer side, slave = memory side.
interface seq_control_unit_if;
  logic mem_req;
  logic mem_ready;
  logic m_r_enbl;
  logic m_w_enbl;

  modport master (
    output mem_req, m_r_enbl, m_w_enbl,
    input  mem_ready
  );

  modport slave (
    input  mem_req, m_r_enbl, m_w_enbl,
    output mem_ready
  );
endinterface

// File: rtl/ctrl_decoder.sv
// Combinational opcode decode: op -> datapath selects and instruction class.
// Ports: op in; reg_sel, alu_src, mem_mux, op_class out.
module ctrl_decoder
  import ctrl_pkg::*;
#(
  parameter int OPC_W = 4
) (
  input  logic [OPC_W-1:0] op,
  output logic             reg_sel,
  output logic             alu_src,
  output logic             mem_mux,
  output op_class_t        op_class
);

  logic       ok;
  logic [3:0] lo;

  // any bit above bit 3 makes the opcode illegal
  assign ok = (op >> 4) == '0;
  assign lo = op[3:0];

  always_comb begin
    reg_sel  = 1'b0;
    alu_src  = 1'b0;
    mem_mux  = 1'b0;
    op_class = CL_ILL;
    unique case (1'b1)
      ok && lo == OP_ADD: begin
        reg_sel  = 1'b1;
        op_class = CL_ALU;
      end
      ok && lo == OP_ADDI: begin
        reg_sel  = 1'b1;
        alu_src  = 1'b1;
        op_class = CL_ALU;
      end
      ok && lo == OP_LW: begin
        reg_sel  = 1'b1;
        alu_src  = 1'b1;
        mem_mux  = 1'b1;
        op_class = CL_LOAD;
      end
      ok && lo == OP_SW: begin
        alu_src  = 1'b1;
        op_class = CL_STORE;
      end
      ok && lo == OP_BEQ: op_class = CL_BRANCH;
      ok && lo == OP_JMP: begin
        reg_sel  = 1'b1;
        op_class = CL_JUMP;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/seq_control_unit.sv
// Multi-cycle sequencer FETCH/DECODE/EXEC/MEM/WB with memory wait timeout.
// Ports: clk, rst_n, opcode, alu_zero, mem (master), strobes/selects, status.
// Optional: CTRL_ILLEGAL_TRAP_EN makes illegal opcodes halt and set illegal.
module seq_control_unit
  import ctrl_pkg::*;
#(
  parameter int OPC_W      = 4,
  parameter int ALU_CTRL_W = 4,
  parameter int MAX_WAIT   = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [OPC_W-1:0]      opcode,
  input  logic                  alu_zero,
  seq_control_unit_if.master    mem,
  output logic                  ir_we,
  output logic                  pc_we,
  output logic [1:0]            pc_src,
  output logic                  reg_sel,
  output logic                  alu_src,
  output logic                  mem_mux,
  output logic                  reg_w_enbl,
  output logic                  br,
  output logic                  jump,
  output logic [ALU_CTRL_W-1:0] to_alu_ctrl,
  output logic                  instr_done,
  output logic                  mem_timeout,
  output logic                  halted,
  output logic                  illegal
);

  localparam int XW = (OPC_W > ALU_CTRL_W) ? OPC_W : ALU_CTRL_W;

  state_t           state, nxt;
  logic [OPC_W-1:0] op_q;
  logic [OPC_W-1:0] dec_op;
  logic [XW-1:0]    op_x;
  logic [7:0]       wait_q;
  logic             wait_inc;
  logic             tmo_set;
  logic             tmo_q;
  logic             sel_on;
  logic             d_rs, d_as, d_mm;
  op_class_t        cls;

  // DECODE sees the live opcode as it is being latched
  assign dec_op = (state == S_DECODE) ? opcode : op_q;

  ctrl_decoder #(.OPC_W(OPC_W)) u_dec (
    .op       (dec_op),
    .reg_sel  (d_rs),
    .alu_src  (d_as),
    .mem_mux  (d_mm),
    .op_class (cls)
  );

  assign sel_on = state inside {S_DECODE, S_EXEC, S_MEM, S_WB};
  assign op_x   = XW'(dec_op);

  assign reg_sel     = sel_on & d_rs;
  assign alu_src     = sel_on & d_as;
  assign mem_mux     = sel_on & d_mm;
  assign to_alu_ctrl = sel_on ? op_x[ALU_CTRL_W-1:0] : '0;
  assign mem_timeout = tmo_q;
  assign halted      = (state == S_HALT);

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic ill_set;
  logic ill_q;
  assign illegal = ill_q;
`else
  assign illegal = 1'b0;
`endif

  always_comb begin
    nxt          = state;
    mem.mem_req  = 1'b0;
    mem.m_r_enbl = 1'b0;
    mem.m_w_enbl = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = PC_INC;
    reg_w_enbl   = 1'b0;
    br           = 1'b0;
    jump         = 1'b0;
    instr_done   = 1'b0;
    wait_inc     = 1'b0;
    tmo_set      = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
    ill_set      = 1'b0;
`endif
    unique case (state)
      S_IDLE: nxt = S_FETCH;
      S_FETCH: begin
        mem.mem_req = 1'b1;
        if (mem.mem_ready) begin
          ir_we = 1'b1;
          pc_we = 1'b1;
          nxt   = S_DECODE;
        end else if (wait_q == 8'(MAX_WAIT)) begin
          tmo_set = 1'b1;
          nxt     = S_HALT;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_DECODE: nxt = S_EXEC;
      S_EXEC: begin
        unique case (cls)
          CL_ALU: nxt = S_WB;
          CL_LOAD, CL_STORE: nxt = S_MEM;
          CL_BRANCH: begin
            br         = 1'b1;
            pc_we      = alu_zero;
            pc_src     = PC_BR;
            instr_done = 1'b1;
            nxt        = S_FETCH;
          end
          CL_JUMP: begin
            jump       = 1'b1;
            pc_we      = 1'b1;
            pc_src     = PC_JMP;
            instr_done = 1'b1;
            nxt        = S_FETCH;
          end
          default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            ill_set    = 1'b1;
            nxt        = S_HALT;
`else
            instr_done = 1'b1;
            nxt        = S_FETCH;
`endif
          end
        endcase
      end
      S_MEM: begin
        mem.mem_req  = 1'b1;
        mem.m_r_enbl = (cls == CL_LOAD);
        mem.m_w_enbl = (cls == CL_STORE);
        if (mem.mem_ready) begin
          if (cls == CL_LOAD) begin
            nxt = S_WB;
          end else begin
            instr_done = 1'b1;
            nxt        = S_FETCH;
          end
        end else if (wait_q == 8'(MAX_WAIT)) begin
          tmo_set = 1'b1;
          nxt     = S_HALT;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_WB: begin
        reg_w_enbl = 1'b1;
        instr_done = 1'b1;
        nxt        = S_FETCH;
      end
      S_HALT: ;
      default: nxt = S_IDLE;
    endcase
  end

  // wait_q only counts while stalled, so it is zero on entry to FETCH/MEM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      op_q   <= '0;
      wait_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      state  <= nxt;
      wait_q <= wait_inc ? wait_q + 8'd1 : 8'd0;
      if (state == S_DECODE) op_q <= opcode;
      if (tmo_set) tmo_q <= 1'b1;
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  always_ff @(posedge clk) begin
    if (!rst_n) ill_q <= 1'b0;
    else if (ill_set) ill_q <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_seq_control_unit.sv
// Randomized self-checking bench for seq_control_unit against a
// per-instruction phase model built from the opcode table.
module tb_seq_control_unit;

  typedef struct packed {
    logic       mem_req;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       reg_sel;
    logic       alu_src;
    logic       mem_mux;
    logic       reg_w_enbl;
    logic       m_r_enbl;
    logic       m_w_enbl;
    logic       br;
    logic       jump;
    logic [3:0] alu;
    logic       instr_done;
    logic       mem_timeout;
    logic       halted;
    logic       illegal;
  } ov_t;

  localparam int MAXW = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] opcode = '0;
  logic       alu_zero = 1'b0;
  logic       ir_we, pc_we, reg_sel, alu_src, mem_mux;
  logic       reg_w_enbl, br, jump, instr_done;
  logic       mem_timeout, halted, illegal;
  logic [1:0] pc_src;
  logic [3:0] to_alu_ctrl;

  int   checks = 0;
  int   failures = 0;
  logic tmo_exp = 1'b0;
  logic ill_exp = 1'b0;

  seq_control_unit_if mif ();

  seq_control_unit #(
    .OPC_W(4), .ALU_CTRL_W(4), .MAX_WAIT(MAXW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .opcode      (opcode),
    .alu_zero    (alu_zero),
    .mem         (mif),
    .ir_we       (ir_we),
    .pc_we       (pc_we),
    .pc_src      (pc_src),
    .reg_sel     (reg_sel),
    .alu_src     (alu_src),
    .mem_mux     (mem_mux),
    .reg_w_enbl  (reg_w_enbl),
    .br          (br),
    .jump        (jump),
    .to_alu_ctrl (to_alu_ctrl),
    .instr_done  (instr_done),
    .mem_timeout (mem_timeout),
    .halted      (halted),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [20:0] got,
                          input logic [20:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic ov_t sample();
    return {mif.mem_req, ir_we, pc_we, pc_src, reg_sel, alu_src, mem_mux,
            reg_w_enbl, mif.m_r_enbl, mif.m_w_enbl, br, jump, to_alu_ctrl,
            instr_done, mem_timeout, halted, illegal};
  endfunction

  function automatic ov_t base();
    ov_t e = '0;
    e.mem_timeout = tmo_exp;
    e.illegal     = ill_exp;
    return e;
  endfunction

  // 0 alu, 1 load, 2 store, 3 branch, 4 jump, 5 illegal
  function automatic int cls(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0100: return 0;
      4'b1011:          return 1;
      4'b1111:          return 2;
      4'b1000:          return 3;
      4'b0010:          return 4;
      default:          return 5;
    endcase
  endfunction

  function automatic ov_t sel(input ov_t e0, input logic [3:0] op);
    ov_t e = e0;
    e.alu = op;
    case (op)
      4'b0000: e.reg_sel = 1'b1;
      4'b0100: begin e.reg_sel = 1'b1; e.alu_src = 1'b1; end
      4'b1011: begin
        e.reg_sel = 1'b1; e.alu_src = 1'b1; e.mem_mux = 1'b1;
      end
      4'b1111: e.alu_src = 1'b1;
      4'b0010: e.reg_sel = 1'b1;
      default: ;
    endcase
    return e;
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [3:0] junk();
    return 4'($urandom);
  endfunction

  task automatic step(input string tag, input logic rdy,
                      input logic [3:0] oc, input logic z, input ov_t e);
    @(negedge clk);
    mif.mem_ready = rdy;
    opcode        = oc;
    alu_zero      = z;
    #1;
    check_eq(tag, sample(), e);
  endtask

  // leaves the DUT in IDLE with the next cycle being FETCH
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mif.mem_ready = rb();
    @(negedge clk);
    rst_n = 1'b1;
    tmo_exp = 1'b0;
    ill_exp = 1'b0;
    #1;
    check_eq("reset_idle", sample(), base());
  endtask

  task automatic fetch(input int fw);
    ov_t e;
    for (int i = 0; i <= fw; i++) begin
      e = base();
      e.mem_req = 1'b1;
      if (i == fw) begin
        e.ir_we = 1'b1;
        e.pc_we = 1'b1;
      end
      step("fetch", i == fw, junk(), rb(), e);
    end
  endtask

  task automatic do_instr(input logic [3:0] op, input int fw,
                          input int mw, input logic z);
    ov_t e;
    int  c = cls(op);
    string t;
    fetch(fw);
    step($sformatf("decode_%b", op), rb(), op, rb(), sel(base(), op));
    e = sel(base(), op);
    case (c)
      3: begin
        e.br = 1'b1; e.pc_we = z; e.pc_src = 2'b01; e.instr_done = 1'b1;
      end
      4: begin
        e.jump = 1'b1; e.pc_we = 1'b1; e.pc_src = 2'b10;
        e.instr_done = 1'b1;
      end
      5: begin
`ifndef CTRL_ILLEGAL_TRAP_EN
        e.instr_done = 1'b1;
`endif
      end
      default: ;
    endcase
    t = $sformatf("exec_%b_z%0d", op, z);
    step(t, rb(), junk(), z, e);
`ifdef CTRL_ILLEGAL_TRAP_EN
    if (c == 5) begin
      ill_exp = 1'b1;
      e = base();
      e.halted = 1'b1;
      step("halt_illegal", rb(), junk(), rb(), e);
      step("halt_illegal", rb(), junk(), rb(), e);
      do_reset();
      return;
    end
`endif
    if (c == 1 || c == 2) begin
      for (int i = 0; i <= mw; i++) begin
        e = sel(base(), op);
        e.mem_req = 1'b1;
        e.m_r_enbl = (c == 1);
        e.m_w_enbl = (c == 2);
        e.instr_done = (c == 2) && (i == mw);
        step($sformatf("mem_%b", op), i == mw, junk(), rb(), e);
      end
    end
    if (c == 0 || c == 1) begin
      e = sel(base(), op);
      e.reg_w_enbl = 1'b1;
      e.instr_done = 1'b1;
      step($sformatf("wb_%b", op), rb(), junk(), rb(), e);
    end
  endtask

  task automatic fetch_timeout();
    ov_t e;
    for (int i = 0; i <= MAXW; i++) begin
      e = base();
      e.mem_req = 1'b1;
      step("fetch_wait", 1'b0, junk(), rb(), e);
    end
    tmo_exp = 1'b1;
    for (int i = 0; i < 3; i++) begin
      e = base();
      e.halted = 1'b1;
      step("halt_timeout", rb(), junk(), rb(), e);
    end
    do_reset();
  endtask

  task automatic sw_reset_mid();
    ov_t e;
    fetch(0);
    step("sw_decode", rb(), 4'b1111, rb(), sel(base(), 4'b1111));
    step("sw_exec", rb(), junk(), rb(), sel(base(), 4'b1111));
    for (int i = 0; i < 2; i++) begin
      e = sel(base(), 4'b1111);
      e.mem_req = 1'b1;
      e.m_w_enbl = 1'b1;
      step("sw_mem_wait", 1'b0, junk(), rb(), e);
    end
    do_reset();
  endtask

  function automatic logic [3:0] pick_op();
    int r = $urandom_range(0, 7);
    case (r)
      0: return 4'b0000;
      1: return 4'b0100;
      2: return 4'b1011;
      3: return 4'b1111;
      4: return 4'b1000;
      5: return 4'b0010;
      default: return junk();
    endcase
  endfunction

  function automatic int pick_wait();
    return ($urandom_range(0, 9) == 0) ? MAXW : $urandom_range(0, 3);
  endfunction

  initial begin
    mif.mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();
    do_instr(4'b0000, 0, 0, 1'b0);
    do_instr(4'b1011, 0, 2, 1'b0);
    do_instr(4'b1000, 0, 0, 1'b1);
    do_instr(4'b1000, 0, 0, 1'b0);
    do_instr(4'b0010, 1, 0, 1'b0);
    do_instr(4'b1111, 0, MAXW, 1'b1);
    do_instr(4'b0100, MAXW, 0, 1'b0);
    do_instr(4'b0001, 0, 0, 1'b0);
    do_instr(4'b0000, 0, 0, 1'b0);
    fetch_timeout();
    do_instr(4'b0100, 0, 0, 1'b0);
    sw_reset_mid();
    do_instr(4'b0000, 0, 0, 1'b0);
    for (int n = 0; n < 300; n++) begin
      do_instr(pick_op(), pick_wait(), pick_wait(), rb());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
